// File: rtl/proc_run_controller.sv
// rtl/proc_run_controller.sv - run/step/halt sequencer gating core commits
// Defining BREAKPOINT_EN enables the PC breakpoint compare.
module proc_run_controller #(
  parameter int          CNT_W      = 16,
  parameter int          CYC_W      = 32,
  parameter logic [31:0] HALT_INSTR = 32'hFFFFFFFF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [31:0]      PC,
  input  logic [31:0]      Instr,
  input  logic [31:0]      bp_addr,
  input  logic             bp_en,
  output logic             CoreEn,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP, S_RUNN} state_t;

  localparam logic [1:0] OP_HALT  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_RUN_N = 2'd3;

  localparam logic [1:0] C_CMD   = 2'd0;
  localparam logic [1:0] C_INSTR = 2'd1;
  localparam logic [1:0] C_BP    = 2'd2;
  localparam logic [1:0] C_DONE  = 2'd3;

  state_t           state_q, state_d;
  logic [1:0]       halt_cause_q, halt_cause_d;
  logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;

  logic running;
  logic halt_cmd;
  logic halt_instr;
  logic bp_hit;
  logic stop_now;

  assign running    = (state_q != S_HALTED);
  assign cmd_ready  = !running || (cmd_op == OP_HALT);
  assign halt_cmd   = running && cmd_valid && (cmd_op == OP_HALT);
  assign halt_instr = running && (Instr == HALT_INSTR);

`ifdef BREAKPOINT_EN
  // first_q lets a resume commit the instruction sitting at the breakpoint.
  assign bp_hit = running && bp_en && (PC == bp_addr) && !first_q;
`else
  logic unused_bp;
  assign unused_bp = ^{PC, bp_addr, bp_en};
  assign bp_hit    = 1'b0;
`endif

  assign stop_now    = halt_cmd || halt_instr || bp_hit;
  assign CoreEn      = running && !stop_now;
  assign halted      = !running;
  assign halt_cause  = halt_cause_q;
  assign cycle_count = cycle_count_q;

  always_comb begin
    state_d       = state_q;
    halt_cause_d  = halt_cause_q;
    cycle_count_d = cycle_count_q;
    remaining_d   = remaining_q;
    first_d       = first_q;

    if (!running) begin
      if (cmd_valid) begin
        case (cmd_op)
          OP_RUN: begin
            state_d = S_RUN;
            first_d = 1'b1;
          end
          OP_STEP: begin
            state_d = S_STEP;
            first_d = 1'b1;
          end
          OP_RUN_N: begin
            if (cmd_arg != '0) begin
              state_d     = S_RUNN;
              remaining_d = cmd_arg;
              first_d     = 1'b1;
            end else begin
              halt_cause_d = C_DONE;
            end
          end
          default: ;
        endcase
      end
    end else if (stop_now) begin
      // A stopping cycle commits nothing and leaves remaining untouched.
      state_d = S_HALTED;
      if (halt_cmd)        halt_cause_d = C_CMD;
      else if (halt_instr) halt_cause_d = C_INSTR;
      else                 halt_cause_d = C_BP;
    end else begin
      first_d       = 1'b0;
      cycle_count_d = cycle_count_q + CYC_W'(1);
      case (state_q)
        S_STEP: begin
          state_d      = S_HALTED;
          halt_cause_d = C_DONE;
        end
        S_RUNN: begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d      = S_HALTED;
            halt_cause_d = C_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_HALTED;
      halt_cause_q  <= C_CMD;
      cycle_count_q <= '0;
      remaining_q   <= '0;
      first_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      halt_cause_q  <= halt_cause_d;
      cycle_count_q <= cycle_count_d;
      remaining_q   <= remaining_d;
      first_q       <= first_d;
    end
  end

endmodule

// File: tb/tb_proc_run_controller.sv
// tb/tb_proc_run_controller.sv - self-checking bench for proc_run_controller
// Expectations follow BREAKPOINT_EN when the bench is built with it defined.
module tb_proc_run_controller;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [1:0] OP_HALT = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_RUN_N = 2'd3;

`ifdef BREAKPOINT_EN
  localparam bit BP_BUILD = 1'b1;
`else
  localparam bit BP_BUILD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = OP_HALT;
  logic [15:0] cmd_arg = '0;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic [31:0] bp_addr = '0;
  logic        bp_en = 1'b0;
  logic        CoreEn;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;

  logic [31:0] mem [64];
  logic [31:0] pc = '0;
  logic        en_s = 1'b0;
  int          commits = 0;
  logic        jump_req = 1'b0;
  logic [31:0] jump_pc = '0;

  int checks = 0;
  int failures = 0;
  int exp_cyc = 0;

  proc_run_controller dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .PC(PC), .Instr(Instr),
    .bp_addr(bp_addr), .bp_en(bp_en), .CoreEn(CoreEn), .halted(halted),
    .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  always #5 CLK = ~CLK;

  // Bench-side core: PC advances by 4 on each committed cycle.
  assign PC    = pc;
  assign Instr = mem[pc[7:2]];

  always @(negedge CLK) begin
    en_s <= CoreEn;
    if (CoreEn) commits <= commits + 1;
  end

  always @(posedge CLK) begin
    if (jump_req)  pc <= jump_pc;
    else if (en_s) pc <= pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_clean();
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT) mem[i] = 32'h0;
    end
    mem[63] = HALT;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      mem[i] = ($urandom_range(0, 5) == 0) ? HALT : ($urandom & 32'h7FFFFFFF);
    end
    mem[63] = HALT;
  endtask

  task automatic jump(input int idx);
    @(posedge CLK); #1;
    jump_req = 1'b1;
    jump_pc  = 32'(idx * 4);
    @(posedge CLK); #1;
    jump_req = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input int arg);
    @(posedge CLK); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg[15:0];
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (halted) break;
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  // Reference: walk the program from the start index, stopping on a count
  // limit, a halt word, or a breakpoint that is not the first instruction.
  // An injected HALT command in cycle j wins if the controller is still running.
  function automatic void predict(input int start, input int lim, input bit bp_on,
                                  input int bp_idx, input int halt_j,
                                  output int k, output int cause);
    bit count_stop;
    k = 0;
    cause = 0;
    count_stop = 1'b0;
    for (int s = 0; s < 200; s++) begin
      if (lim >= 0 && k == lim) begin cause = 3; count_stop = 1'b1; break; end
      if (mem[(start + k) % 64] == HALT) begin cause = 1; break; end
      if (bp_on && ((start + k) % 64) == bp_idx && k != 0) begin cause = 2; break; end
      k++;
    end
    if (halt_j > 0 && (count_stop ? (halt_j <= k) : (halt_j <= k + 1))) begin
      k = halt_j - 1;
      cause = 0;
    end
  endfunction

  task automatic do_run(input string tag, input logic [1:0] op, input int arg, input int halt_j);
    int c0, start, lim, k, cause;
    bit idle;
    start = int'(pc[7:2]);
    lim   = (op == OP_RUN) ? -1 : (op == OP_STEP) ? 1 : arg;
    predict(start, lim, BP_BUILD && bp_en, int'(bp_addr[7:2]), halt_j, k, cause);
    idle = (op == OP_RUN_N && arg == 0);
    c0 = commits;
    issue(op, arg);
    cmd_op = OP_RUN;
    #1;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'(idle));
    if (halt_j >= 2) begin
      repeat (halt_j - 2) @(posedge CLK);
      issue(OP_HALT, 0);
    end
    wait_halt(tag);
    exp_cyc += k;
    chk({tag, "_commits"}, 32'(commits - c0), 32'(k));
    chk({tag, "_cause"}, 32'(halt_cause), 32'(cause));
    chk({tag, "_cycles"}, cycle_count, 32'(exp_cyc));
    chk({tag, "_pc"}, pc, 32'((start + k) * 4));
  endtask

  initial begin
    fill_clean();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    cmd_op = OP_RUN;
    repeat (2) @(negedge CLK);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_coreen", 32'(CoreEn), 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    chk("rst_cause", 32'(halt_cause), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    jump(0);
    do_run("step", OP_STEP, 0, 0);
    issue(OP_HALT, 0);
    @(negedge CLK);
    chk("halt_idle_cause", 32'(halt_cause), 32'd3);
    chk("halt_idle_halted", 32'(halted), 32'd1);

    do_run("runn5", OP_RUN_N, 5, 0);

    fill_clean();
    mem[3] = HALT;
    jump(0);
    do_run("halt_instr", OP_RUN, 0, 0);
    do_run("runn0", OP_RUN_N, 0, 0);

    fill_clean();
    mem[5] = HALT;
    bp_en = 1'b1;
    bp_addr = 32'd8;
    jump(0);
    do_run("bp_stop", OP_RUN, 0, 0);
    do_run("bp_resume", OP_RUN, 0, 0);
    bp_en = 1'b0;

    fill_clean();
    jump(0);
    do_run("halt_cmd10", OP_RUN, 0, 10);

    mem[4] = HALT;
    jump(0);
    do_run("halt_with_instr", OP_RUN, 0, 5);
    mem[4] = 32'h0;

    jump(0);
    do_run("halt_last_runn", OP_RUN_N, 4, 4);

    jump(0);
    issue(OP_RUN, 0);
    repeat (5) @(posedge CLK);
    #1;
    chk("midrun_coreen_before", 32'(CoreEn), 32'd1);
    RST = 1'b0;
    #1;
    chk("midrun_coreen", 32'(CoreEn), 32'd0);
    chk("midrun_halted", 32'(halted), 32'd1);
    chk("midrun_cycles", cycle_count, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    exp_cyc = 0;

    for (int i = 0; i < 25; i++) begin
      logic [1:0] op;
      int arg, hj;
      fill_random();
      bp_en   = 1'($urandom_range(0, 1));
      bp_addr = 32'($urandom_range(0, 63) * 4);
      op      = 2'($urandom_range(1, 3));
      arg     = $urandom_range(0, 10);
      hj      = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 15) : 0;
      jump($urandom_range(0, 62));
      do_run($sformatf("rnd%0d", i), op, arg, hj);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/proc_run_controller.md
Name: proc_run_controller

Overview:
Run/step/halt sequencer for the single-cycle processor core. It drives CoreEn, which the core uses as the write enable for PCReg, RegisterFile WE3 and DataMemory WE. While CoreEn=0 the architectural state is frozen. The block accepts debug commands over a valid/ready port, stops on a halt instruction or a breakpoint, and counts committed cycles.

Parameters:
CNT_W, 16, width of the RUN_N cycle-count argument
CYC_W, 32, width of the committed-cycle counter
HALT_INSTR, 32'hFFFFFFFF, instruction encoding treated as halt (never committed)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid&&ready
cmd_op  input  2  0=HALT, 1=RUN, 2=STEP, 3=RUN_N
cmd_arg  input  CNT_W  cycle count for RUN_N
PC  input  32  current PC from core
Instr  input  32  current instruction from core
bp_addr  input  32  breakpoint PC
bp_en  input  1  breakpoint enable
CoreEn  output  1  core commit enable (combinational)
halted  output  1  state==HALTED
halt_cause  output  2  0=CMD, 1=HALT_INSTR, 2=BREAKPOINT, 3=COUNT_DONE
cycle_count  output  CYC_W  number of committed cycles

Behaviour:
- States: HALTED, RUN, STEP, RUNN. The state is registered. Reset (RST=0) forces HALTED immediately, at any time, including mid-RUN.
- Reset values: CoreEn=0, halted=1, halt_cause=0, cycle_count=0, remaining=0, first=0.
- cmd_ready = (state==HALTED) || (cmd_op==HALT). In non-HALTED states, RUN, STEP and RUN_N are back-pressured.
- Accepted in HALTED:
  - RUN -> RUN.
  - STEP -> STEP.
  - RUN_N with arg N>0 -> RUNN with remaining=N.
  - RUN_N with N=0 -> stay HALTED, halt_cause=COUNT_DONE.
  - HALT -> no change.
- Any transition out of HALTED sets first=1. first clears after one CoreEn=1 cycle.
- stop_now is combinational while state!=HALTED. Priority, highest first:
  1. Accepted HALT command: cause CMD.
  2. Instr==HALT_INSTR: cause HALT_INSTR.
  3. bp_en && PC==bp_addr && !first: cause BREAKPOINT.
- CoreEn = (state!=HALTED) && !stop_now. A stopping instruction is never committed.
- On stop_now: next state is HALTED and halt_cause is loaded with the cause.
- STEP: one CoreEn cycle, then HALTED with cause COUNT_DONE.
- RUNN: each CoreEn cycle decrements remaining. When a CoreEn cycle occurs with remaining==1, the next state is HALTED with cause COUNT_DONE. Exactly N commits occur.
- A stop_now cycle has CoreEn=0 and does not decrement remaining.
- The `first` flag lets a resume step off the instruction at the breakpoint. A halt instruction still stops immediately, even on the first cycle.
- cycle_count increments on every cycle with CoreEn=1. It wraps modulo 2^CYC_W and is cleared only by reset.
- Simultaneous events:
  - HALT command in the same cycle as a halt instruction: cause CMD.
  - HALT command during the last RUNN cycle: cause CMD, CoreEn=0.

Optional Feature:
BREAKPOINT_EN:
- Defined: breakpoint compare as described.
- Undefined: bp_addr and bp_en are ignored, the breakpoint term is constant 0, and halt_cause never equals 2. All other behaviour is identical.

Test Plan:
- Release reset, no commands -> halted=1, CoreEn=0, cycle_count=0; assert RST=0 mid-RUN -> CoreEn=0 in the same cycle, halted=1.
- STEP from HALTED -> exactly one CoreEn pulse, cycle_count=1, halt_cause=3; cmd_ready=0 for RUN while in STEP.
- RUN_N arg=5 -> exactly 5 CoreEn cycles, cycle_count=5, halt_cause=3; RUN_N arg=0 -> zero CoreEn cycles, halt_cause=3.
- RUN with Instr=32'hFFFFFFFF presented on the 4th enabled cycle -> 3 commits, CoreEn=0 on that cycle, halt_cause=1.
- BREAKPOINT_EN, bp_en=1, bp_addr=8, PC reaches 8 -> CoreEn=0, halt_cause=2; then RUN -> commit at PC 8 is allowed (first=1), continues running.
- RUN, then HALT command on cycle 10 -> 9 commits, CoreEn=0 in cycle 10, halt_cause=0; HALT together with halt instruction -> cause 0.
